// File: rtl/fetch_predict.sv
// fetch_predict: IF stage with 2-bit BHT, J follow and in-flight BEQ queue.
// Define BP_STATS_EN to add resolve/mispredict counters and a trace line.
module fetch_predict #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int          BHT_IDX_W    = 4,
  parameter int          BQ_DEPTH     = 4,
  parameter int          FLUSH_CYCLES = 2
) (
  input  logic               clk_x70,
  input  logic               rst_n_x70,
  input  logic               hold_x70,
  output logic [31:0]        imem_addr_x70,
  input  logic [31:0]        imem_data_x70,
  output logic [31:0]        instr_x70,
  output logic [31:0]        pc_x70,
  output logic               valid_x70,
  output logic               predicted_x70,
  input  logic               resolve_x70,
  input  logic               stall_x70,
  input  logic signed [25:0] pc_inc_x70,
  output logic               flush_x70
`ifdef BP_STATS_EN
  ,
  output logic [31:0]        br_count_x70,
  output logic [31:0]        mispredict_count_x70
`endif
);

  localparam int QW = $clog2(BQ_DEPTH);
  localparam int BN = 1 << BHT_IDX_W;
  localparam int FW =
    (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [FW-1:0] FLAST = FW'(FLUSH_CYCLES - 1);
  localparam logic [QW:0]   QFULL = (QW+1)'(BQ_DEPTH);

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    BQ_WAIT = 2'd1,
    FLUSH   = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [31:0]     pc_q, pc_d;
  logic [31:0]     instr_q, instr_d;
  logic [31:0]     opc_q, opc_d;
  logic            valid_q, valid_d;
  logic            pred_q, pred_d;
  logic            flush_q, flush_d;
  logic [FW-1:0]   fcnt_q, fcnt_d;

  logic [1:0]      bht_q [BN];
  logic [31:0]     bq_pc_q [BQ_DEPTH];
  logic            bq_pred_q [BQ_DEPTH];
  logic [QW-1:0]   rd_q, wr_q;
  logic [QW:0]     cnt_q, cnt_d;

  logic                 is_beq, is_j, pred_bit;
  logic                 pop, taken, mispred;
  logic                 can_push, push;
  logic [BHT_IDX_W-1:0] f_idx, r_idx;
  logic [31:0]          seq_pc, br_off, br_pc, j_pc;
  logic [31:0]          hd_pc, redir_pc;
  logic                 hd_pred;
  logic [1:0]           r_ctr, r_ctr_d;

  assign imem_addr_x70 = pc_q;
  assign instr_x70     = instr_q;
  assign pc_x70        = opc_q;
  assign valid_x70     = valid_q;
  assign predicted_x70 = pred_q;
  assign flush_x70     = flush_q;

  assign is_beq   = imem_data_x70[31:26] == 6'b000100;
  assign is_j     = imem_data_x70[31:26] == 6'b000010;
  assign f_idx    = pc_q[BHT_IDX_W+1:2];
  assign pred_bit = bht_q[f_idx][1];
  assign seq_pc   = pc_q + 32'd4;
  assign br_off   = {{14{imem_data_x70[15]}},
                     imem_data_x70[15:0], 2'b00};
  assign br_pc    = seq_pc + br_off;
  assign j_pc     = {pc_q[31:28],
                     imem_data_x70[25:0], 2'b00};

  assign hd_pc    = bq_pc_q[rd_q];
  assign hd_pred  = bq_pred_q[rd_q];
  assign r_idx    = hd_pc[BHT_IDX_W+1:2];
  assign r_ctr    = bht_q[r_idx];
  assign pop      = resolve_x70 && (cnt_q != '0);
  assign taken    = hd_pred ^ stall_x70;
  assign mispred  = pop && stall_x70;
  assign redir_pc = hd_pc + 32'd4 +
                    {{6{pc_inc_x70[25]}}, pc_inc_x70};
  assign can_push = (cnt_q != QFULL) || pop;

  // Saturating 2-bit counter step for the resolving branch.
  always_comb begin
    r_ctr_d = r_ctr;
    if (taken) begin
      if (r_ctr != 2'b11) r_ctr_d = r_ctr + 2'd1;
    end else begin
      if (r_ctr != 2'b00) r_ctr_d = r_ctr - 2'd1;
    end
  end

  // Next PC, output stage and FSM state selection.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    opc_d   = opc_q;
    valid_d = valid_q;
    pred_d  = pred_q;
    flush_d = 1'b0;
    fcnt_d  = fcnt_q;
    push    = 1'b0;
    if (mispred) begin
      state_d = FLUSH;
      pc_d    = redir_pc;
      fcnt_d  = '0;
      instr_d = '0;
      valid_d = 1'b0;
      pred_d  = 1'b0;
      flush_d = 1'b1;
    end else if (state_q == FLUSH) begin
      instr_d = '0;
      valid_d = 1'b0;
      pred_d  = 1'b0;
      if (fcnt_q == FLAST) begin
        state_d = FETCH;
      end else begin
        fcnt_d  = fcnt_q + FW'(1);
        flush_d = 1'b1;
      end
    end else if (hold_x70) begin
      state_d = state_q;
    end else if (is_beq && !can_push) begin
      state_d = BQ_WAIT;
      instr_d = '0;
      opc_d   = pc_q;
      valid_d = 1'b0;
      pred_d  = 1'b0;
    end else begin
      state_d = FETCH;
      instr_d = imem_data_x70;
      opc_d   = pc_q;
      valid_d = 1'b1;
      pred_d  = is_beq && pred_bit;
      push    = is_beq;
      unique case (1'b1)
        is_j:                pc_d = j_pc;
        is_beq && pred_bit:  pc_d = br_pc;
        default:             pc_d = seq_pc;
      endcase
    end
  end

  assign cnt_d = cnt_q + {{QW{1'b0}}, push}
                       - {{QW{1'b0}}, pop};

  // State, PC, output registers, queue pointers and BHT.
  always_ff @(posedge clk_x70) begin
    if (!rst_n_x70) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      opc_q   <= '0;
      valid_q <= 1'b0;
      pred_q  <= 1'b0;
      flush_q <= 1'b0;
      fcnt_q  <= '0;
      rd_q    <= '0;
      wr_q    <= '0;
      cnt_q   <= '0;
      for (int i = 0; i < BN; i++) bht_q[i] <= 2'b01;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      opc_q   <= opc_d;
      valid_q <= valid_d;
      pred_q  <= pred_d;
      flush_q <= flush_d;
      fcnt_q  <= fcnt_d;
      if (mispred) begin
        rd_q  <= '0;
        wr_q  <= '0;
        cnt_q <= '0;
      end else begin
        if (push) wr_q <= wr_q + QW'(1);
        if (pop)  rd_q <= rd_q + QW'(1);
        cnt_q <= cnt_d;
      end
      if (pop) bht_q[r_idx] <= r_ctr_d;
    end
  end

  // Queue payload storage; contents are don't-care while empty.
  always_ff @(posedge clk_x70) begin
    if (push) begin
      bq_pc_q[wr_q]   <= pc_q;
      bq_pred_q[wr_q] <= pred_bit;
    end
  end

`ifdef BP_STATS_EN
  logic [31:0] br_cnt_q, mis_cnt_q;

  // Resolve and mispredict counters with a trace per redirect.
  always_ff @(posedge clk_x70) begin
    if (!rst_n_x70) begin
      br_cnt_q  <= '0;
      mis_cnt_q <= '0;
    end else begin
      if (pop) br_cnt_q <= br_cnt_q + 32'd1;
      if (mispred) begin
        mis_cnt_q <= mis_cnt_q + 32'd1;
        $display("fetch_predict: mispredict pc=%08h target=%08h",
                 hd_pc, redir_pc);
      end
    end
  end

  assign br_count_x70         = br_cnt_q;
  assign mispredict_count_x70 = mis_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_predict.sv
// tb_fetch_predict: directed scenarios plus randomized run of fetch_predict
// against a queue/array reference model.
module tb_fetch_predict;
  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam int          FLC    = 2;
  localparam int          DEPTH  = 4;

  logic               clk = 1'b0;
  logic               rst_n, hold, resolve, stall;
  logic signed [25:0] pcinc;
  logic [31:0]        imem_addr, imem_data, instr, pcx;
  logic               valid, pred, flush;
  logic [31:0]        mem [256];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign imem_data = mem[imem_addr[9:2]];

  fetch_predict #(
    .RESET_PC(RST_PC), .BHT_IDX_W(4),
    .BQ_DEPTH(DEPTH), .FLUSH_CYCLES(FLC)
  ) dut (
    .clk_x70(clk), .rst_n_x70(rst_n), .hold_x70(hold),
    .imem_addr_x70(imem_addr), .imem_data_x70(imem_data),
    .instr_x70(instr), .pc_x70(pcx), .valid_x70(valid),
    .predicted_x70(pred), .resolve_x70(resolve),
    .stall_x70(stall), .pc_inc_x70(pcinc), .flush_x70(flush)
  );

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] pc;
    bit          pred;
  } bq_t;

  bq_t         mq[$];
  int          mbht [16];
  logic [31:0] m_pc, m_instr, m_opc;
  bit          m_valid, m_pred, m_flush;
  int          m_mode;
  int          m_left;

  task automatic model_step();
    logic [31:0] w, tgt;
    bit beq, jmp, p, tk, mis;
    bq_t e;
    int bi;
    if (!rst_n) begin
      m_pc = RST_PC; m_instr = 0; m_opc = 0;
      m_valid = 0; m_pred = 0; m_flush = 0;
      m_mode = 0; m_left = 0;
      mq.delete();
      foreach (mbht[i]) mbht[i] = 1;
      return;
    end
    w   = mem[m_pc[9:2]];
    beq = (w[31:26] == 6'b000100);
    jmp = (w[31:26] == 6'b000010);
    p   = (mbht[m_pc[5:2]] >= 2);
    mis = 0;
    tgt = 0;
    if (resolve && mq.size() != 0) begin
      e  = mq.pop_front();
      bi = int'(e.pc[5:2]);
      tk = e.pred ^ stall;
      if (tk) begin
        if (mbht[bi] < 3) mbht[bi]++;
      end else begin
        if (mbht[bi] > 0) mbht[bi]--;
      end
      if (stall) begin
        mis = 1;
        tgt = e.pc + 32'd4 + 32'(int'(pcinc));
      end
    end
    if (mis) begin
      mq.delete();
      m_pc = tgt; m_mode = 2; m_left = FLC - 1;
      m_valid = 0; m_pred = 0; m_instr = 0; m_flush = 1;
    end else if (m_mode == 2) begin
      m_valid = 0; m_pred = 0; m_instr = 0;
      if (m_left == 0) begin
        m_mode = 0; m_flush = 0;
      end else begin
        m_left--; m_flush = 1;
      end
    end else if (hold) begin
      m_flush = 0;
    end else if (beq && mq.size() >= DEPTH) begin
      m_mode = 1; m_valid = 0; m_pred = 0; m_instr = 0;
    end else begin
      m_mode = 0; m_instr = w; m_opc = m_pc;
      m_valid = 1; m_pred = beq && p;
      if (beq) mq.push_back('{m_pc, p});
      if (jmp)
        m_pc = {m_pc[31:28], w[25:0], 2'b00};
      else if (beq && p)
        m_pc = m_pc + 32'd4 + 32'(int'($signed(w[15:0])) * 4);
      else
        m_pc = m_pc + 32'd4;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  function automatic logic [31:0] w_beq(input logic [15:0] imm);
    return {6'b000100, 10'd0, imm};
  endfunction

  function automatic logic [31:0] w_j(input logic [25:0] f);
    return {6'b000010, f};
  endfunction

  function automatic logic [31:0] w_alu(input int k);
    return {6'b001000, 26'(k)};
  endfunction

  task automatic fill_plain();
    for (int i = 0; i < 256; i++) mem[i] = w_alu(i + 1);
  endtask

  task automatic do_reset();
    rst_n = 0; hold = 0; resolve = 0; stall = 0; pcinc = '0;
    tick(); tick();
    rst_n = 1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    fill_plain();
    do_reset();
    n_vec++; if (imem_addr !== RST_PC) begin n_err++;
      $display("FAIL rst_addr got %h exp %h", imem_addr, RST_PC); end
    n_vec++; if (valid !== 1'b0) begin n_err++;
      $display("FAIL rst_valid got %b exp 0", valid); end
    n_vec++; if (flush !== 1'b0) begin n_err++;
      $display("FAIL rst_flush got %b exp 0", flush); end
    n_vec++; if (instr !== 32'h0) begin n_err++;
      $display("FAIL rst_instr got %h exp 0", instr); end
    n_vec++; if (pcx !== 32'h0) begin n_err++;
      $display("FAIL rst_pc got %h exp 0", pcx); end
    n_vec++; if (pred !== 1'b0) begin n_err++;
      $display("FAIL rst_pred got %b exp 0", pred); end
  endtask

  task automatic test_straight();
    fill_plain();
    do_reset();
    for (int k = 0; k < 6; k++) begin
      tick();
      n_vec++; if (imem_addr !== 32'(4 * (k + 1))) begin n_err++;
        $display("FAIL seq_addr k%0d got %h exp %h", k, imem_addr, 4*(k+1)); end
      n_vec++; if (instr !== w_alu(k + 1)) begin n_err++;
        $display("FAIL seq_instr k%0d got %h exp %h", k, instr, w_alu(k+1)); end
      n_vec++; if (pcx !== 32'(4 * k)) begin n_err++;
        $display("FAIL seq_pc k%0d got %h exp %h", k, pcx, 4*k); end
      n_vec++; if (valid !== 1'b1) begin n_err++;
        $display("FAIL seq_valid k%0d got %b exp 1", k, valid); end
    end
  endtask

  task automatic test_jump();
    fill_plain();
    mem[4] = w_j(26'h40);
    do_reset();
    repeat (4) tick();
    n_vec++; if (imem_addr !== 32'h10) begin n_err++;
      $display("FAIL j_pre got %h exp 00000010", imem_addr); end
    tick();
    n_vec++; if (imem_addr !== 32'h100) begin n_err++;
      $display("FAIL j_target got %h exp 00000100", imem_addr); end
    n_vec++; if (instr !== w_j(26'h40) || valid !== 1'b1) begin n_err++;
      $display("FAIL j_instr got %h/%b exp %h/1", instr, valid, w_j(26'h40)); end
    tick();
    n_vec++; if (valid !== 1'b1 || pcx !== 32'h100) begin n_err++;
      $display("FAIL j_nobubble got %b/%h exp 1/00000100", valid, pcx); end
    n_vec++; if (instr !== w_alu(65)) begin n_err++;
      $display("FAIL j_tgt_instr got %h exp %h", instr, w_alu(65)); end
  endtask

  task automatic test_mispredict();
    fill_plain();
    mem[8]  = w_beq(16'd3);
    mem[12] = w_j(26'd8);
    do_reset();
    repeat (8) tick();
    tick();
    n_vec++; if (imem_addr !== 32'h24 || pred !== 1'b0) begin n_err++;
      $display("FAIL mp_nt_fetch got %h/%b exp 00000024/0", imem_addr, pred); end
    resolve = 1; stall = 1; pcinc = 26'sd12;
    tick();
    resolve = 0; stall = 0; pcinc = '0;
    n_vec++; if (imem_addr !== 32'h30) begin n_err++;
      $display("FAIL mp_redir got %h exp 00000030", imem_addr); end
    n_vec++; if (flush !== 1'b1 || valid !== 1'b0) begin n_err++;
      $display("FAIL mp_flush1 got %b/%b exp 1/0", flush, valid); end
    tick();
    n_vec++; if (flush !== 1'b1 || valid !== 1'b0) begin n_err++;
      $display("FAIL mp_flush2 got %b/%b exp 1/0", flush, valid); end
    tick();
    n_vec++; if (flush !== 1'b0 || valid !== 1'b0 || imem_addr !== 32'h30)
      begin n_err++;
      $display("FAIL mp_flush_end got %b/%b/%h exp 0/0/00000030",
               flush, valid, imem_addr); end
    tick();
    n_vec++; if (valid !== 1'b1 || pcx !== 32'h30) begin n_err++;
      $display("FAIL mp_resume got %b/%h exp 1/00000030", valid, pcx); end
    tick();
    n_vec++; if (pred !== 1'b1 || imem_addr !== 32'h30) begin n_err++;
      $display("FAIL mp_bht10 got %b/%h exp 1/00000030", pred, imem_addr); end
    resolve = 1; stall = 0;
    tick();
    resolve = 0;
    n_vec++; if (imem_addr !== 32'h20 || flush !== 1'b0) begin n_err++;
      $display("FAIL mp_ok_resolve got %h/%b exp 00000020/0", imem_addr, flush); end
    tick();
    n_vec++; if (pred !== 1'b1 || imem_addr !== 32'h30) begin n_err++;
      $display("FAIL mp_bht11 got %b/%h exp 1/00000030", pred, imem_addr); end
    resolve = 1; stall = 1; pcinc = '0;
    tick();
    resolve = 0; stall = 0;
    n_vec++; if (imem_addr !== 32'h24 || flush !== 1'b1) begin n_err++;
      $display("FAIL mp_t_redir got %h/%b exp 00000024/1", imem_addr, flush); end
    repeat (3) tick();
    n_vec++; if (valid !== 1'b1 || pcx !== 32'h24) begin n_err++;
      $display("FAIL mp_t_resume got %b/%h exp 1/00000024", valid, pcx); end
    repeat (3) tick();
    tick();
    n_vec++; if (pred !== 1'b1 || imem_addr !== 32'h30) begin n_err++;
      $display("FAIL mp_bht_after got %b/%h exp 1/00000030", pred, imem_addr); end
    resolve = 1; stall = 1; pcinc = '0;
    tick();
    resolve = 0; stall = 0;
    repeat (6) tick();
    tick();
    n_vec++; if (pred !== 1'b0 || imem_addr !== 32'h24) begin n_err++;
      $display("FAIL mp_bht01 got %b/%h exp 0/00000024", pred, imem_addr); end
  endtask

  task automatic test_bq_full();
    fill_plain();
    for (int i = 0; i < 5; i++) mem[i] = w_beq(16'd5);
    do_reset();
    repeat (4) tick();
    n_vec++; if (imem_addr !== 32'h10 || valid !== 1'b1) begin n_err++;
      $display("FAIL bq_fill got %h/%b exp 00000010/1", imem_addr, valid); end
    tick();
    n_vec++; if (valid !== 1'b0 || imem_addr !== 32'h10) begin n_err++;
      $display("FAIL bq_wait1 got %b/%h exp 0/00000010", valid, imem_addr); end
    tick();
    n_vec++; if (valid !== 1'b0 || imem_addr !== 32'h10) begin n_err++;
      $display("FAIL bq_wait2 got %b/%h exp 0/00000010", valid, imem_addr); end
    resolve = 1; stall = 0;
    tick();
    resolve = 0;
    n_vec++; if (valid !== 1'b1 || pcx !== 32'h10 || imem_addr !== 32'h14)
      begin n_err++;
      $display("FAIL bq_resume got %b/%h/%h exp 1/00000010/00000014",
               valid, pcx, imem_addr); end
  endtask

  task automatic test_hold_redirect();
    fill_plain();
    for (int i = 0; i < 3; i++) mem[i] = w_beq(16'd5);
    do_reset();
    repeat (3) tick();
    n_vec++; if (imem_addr !== 32'h0C) begin n_err++;
      $display("FAIL hr_pre got %h exp 0000000c", imem_addr); end
    hold = 1; resolve = 1; stall = 1; pcinc = 26'sh40;
    tick();
    hold = 0;
    n_vec++; if (imem_addr !== 32'h44 || flush !== 1'b1 || valid !== 1'b0)
      begin n_err++;
      $display("FAIL hr_redir got %h/%b/%b exp 00000044/1/0",
               imem_addr, flush, valid); end
    tick();
    resolve = 0; stall = 0; pcinc = '0;
    n_vec++; if (imem_addr !== 32'h44 || flush !== 1'b1) begin n_err++;
      $display("FAIL hr_qempty got %h/%b exp 00000044/1", imem_addr, flush); end
    rst_n = 0;
    tick();
    rst_n = 1;
    n_vec++; if (imem_addr !== RST_PC || flush !== 1'b0 || valid !== 1'b0)
      begin n_err++;
      $display("FAIL hr_rst got %h/%b/%b exp %h/0/0",
               imem_addr, flush, valid, RST_PC); end
    tick();
    n_vec++; if (valid !== 1'b1 || pcx !== RST_PC) begin n_err++;
      $display("FAIL hr_fetch got %b/%h exp 1/%h", valid, pcx, RST_PC); end
  endtask

  task automatic test_random();
    logic [15:0] imm;
    for (int i = 0; i < 256; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2: begin
          imm = 16'($urandom_range(0, 31)) - 16'd16;
          mem[i] = {6'b000100, 10'($urandom), imm};
        end
        3: mem[i] = w_j(26'($urandom_range(0, 255)));
        default: mem[i] = {6'b001000, 26'($urandom)};
      endcase
    end
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      rst_n   = ($urandom_range(0, 299) != 0);
      hold    = ($urandom_range(0, 6) == 0);
      resolve = ($urandom_range(0, 2) == 0);
      stall   = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 3) == 0) pcinc = '0;
      else pcinc = 26'(int'($urandom_range(0, 63)) * 4 - 128);
      tick();
      n_vec++; if (imem_addr !== m_pc) begin n_err++;
        $display("FAIL rnd_addr c%0d got %h exp %h", c, imem_addr, m_pc); end
      n_vec++; if (valid !== m_valid) begin n_err++;
        $display("FAIL rnd_valid c%0d got %b exp %b", c, valid, m_valid); end
      n_vec++; if (flush !== m_flush) begin n_err++;
        $display("FAIL rnd_flush c%0d got %b exp %b", c, flush, m_flush); end
      if (m_valid) begin
        n_vec++;
        if (instr !== m_instr || pcx !== m_opc || pred !== m_pred) begin
          n_err++;
          $display("FAIL rnd_out c%0d got %h/%h/%b exp %h/%h/%b",
                   c, instr, pcx, pred, m_instr, m_opc, m_pred);
        end
      end
    end
    rst_n = 1; hold = 0; resolve = 0; stall = 0;
  endtask

  initial begin
    rst_n = 0; hold = 0; resolve = 0; stall = 0; pcinc = '0;
    test_reset();
    test_straight();
    test_jump();
    test_mispredict();
    test_bq_full();
    test_hold_redirect();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
